// File: rtl/singlecycle_pkg.sv
// Shared types for the single-cycle core's display path: BCD converter state
// encoding and the per-digit 7-segment lookup.
package singlecycle_pkg;

    typedef enum logic [1:0] {
        BCD_IDLE  = 2'd0,
        BCD_SHIFT = 2'd1,
        BCD_DONE  = 2'd2
    } BcdState_e;

    localparam int BCDSTATE_W = $bits(BcdState_e);

    // Segment order {g,f,e,d,c,b,a}, active high; non-decimal codes are blanked.
    function automatic logic [6:0] bcd_to_7seg(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = 7'b0111111;
            4'd1:    seg = 7'b0000110;
            4'd2:    seg = 7'b1011011;
            4'd3:    seg = 7'b1001111;
            4'd4:    seg = 7'b1100110;
            4'd5:    seg = 7'b1101101;
            4'd6:    seg = 7'b1111101;
            4'd7:    seg = 7'b0000111;
            4'd8:    seg = 7'b1111111;
            4'd9:    seg = 7'b1101111;
            default: seg = 7'b0000000;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/bin_to_bcd_seq_add3.sv
// Double-dabble digit corrector: a BCD digit of 5 or more gets +3 so that the
// following left shift carries correctly into the next decimal digit.
module bcd_add3 (
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);

    assign o_digit = (i_digit >= 4'd5) ? i_digit + 4'd3 : i_digit;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock) feeding
// the per-digit 7-segment lookup of the display path.
module bin_to_bcd_seq
    import singlecycle_pkg::*;
#(
    parameter int BIN_W  = 32,
    parameter int DIGITS = 10
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic [BIN_W-1:0]      i_bin,
    input  logic                  i_signed,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [4*DIGITS-1:0]   o_bcd,
    output logic                  o_neg
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(BIN_W - 1);

    BcdState_e          state_q, state_d;
    logic [BIN_W-1:0]   mag_q, mag_d;
    logic [BCD_W-1:0]   scratch_q, scratch_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sign_q, sign_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               neg_q, neg_d;

    logic [BCD_W-1:0]   scratch_adj;
    logic [BIN_W-1:0]   bin_abs;
    logic               bin_is_neg;

    for (genvar k = 0; k < DIGITS; k++) begin : g_add3
        bcd_add3 u_add3 (
            .i_digit (scratch_q[4*k +: 4]),
            .o_digit (scratch_adj[4*k +: 4])
        );
    end

    // Negation is taken modulo 2^BIN_W, so the most negative input maps onto
    // its own bit pattern, which read unsigned is exactly its magnitude.
    assign bin_is_neg = i_signed & i_bin[BIN_W-1];
    assign bin_abs    = bin_is_neg ? (~i_bin + {{(BIN_W-1){1'b0}}, 1'b1}) : i_bin;

    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        mag_d     = mag_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        sign_d    = sign_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        bcd_d     = bcd_q;
        neg_d     = neg_q;

        case (state_q)
            BCD_IDLE: begin
                // busy_q still high here means the done pulse is showing;
                // a start in that cycle is dropped like any other busy start.
                busy_d = 1'b0;
                if (i_start && !busy_q) begin
                    mag_d     = bin_abs;
                    sign_d    = bin_is_neg;
                    scratch_d = '0;
                    cnt_d     = '0;
                    busy_d    = 1'b1;
                    state_d   = BCD_SHIFT;
                end
            end
            BCD_SHIFT: begin
                scratch_d = {scratch_adj[BCD_W-2:0], mag_q[BIN_W-1]};
                mag_d     = {mag_q[BIN_W-2:0], 1'b0};
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == LAST_SHIFT) begin
                    state_d = BCD_DONE;
                end
            end
            BCD_DONE: begin
                bcd_d   = scratch_q;
                neg_d   = sign_q;
                done_d  = 1'b1;
                state_d = BCD_IDLE;
            end
            default: begin
                state_d = BCD_IDLE;
            end
        endcase
    end

    // NOTE: state is updated with non-blocking assignments only, so every flop
    // samples the values from before this edge regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= BCD_IDLE;
            mag_q     <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            sign_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            bcd_q     <= '0;
            neg_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            mag_q     <= mag_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            sign_q    <= sign_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            bcd_q     <= bcd_d;
            neg_q     <= neg_d;
        end
    end

    assign o_busy = busy_q;
    assign o_done = done_q;
    assign o_bcd  = bcd_q;
    assign o_neg  = neg_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed scoreboard bench for bin_to_bcd_seq: expected BCD/sign pushed when a
// conversion is started, popped and compared when o_done pulses.
module tb_bin_to_bcd_seq;

    localparam int BIN_W   = 32;
    localparam int DIGITS  = 10;
    localparam int LATENCY = BIN_W + 2;

    logic                clk;
    logic                rst_n;
    logic                start;
    logic [BIN_W-1:0]    bin;
    logic                sgn;
    logic                busy;
    logic                done;
    logic [4*DIGITS-1:0] bcd;
    logic                neg;

    int cmp_cnt = 0;
    int err_cnt = 0;

    logic [4*DIGITS:0] sb[$];
    logic [4*DIGITS-1:0] last_bcd;
    logic                last_neg;

    bin_to_bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_start  (start),
        .i_bin    (bin),
        .i_signed (sgn),
        .o_busy   (busy),
        .o_done   (done),
        .o_bcd    (bcd),
        .o_neg    (neg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: magnitude by two's-complement negation, digits by repeated /10.
    function automatic logic [4*DIGITS:0] model(input logic [BIN_W-1:0] v, input logic s);
        logic [BIN_W-1:0]    m;
        logic [4*DIGITS-1:0] r;
        logic                n;
        n = s && v[BIN_W-1];
        m = n ? (0 - v) : v;
        r = '0;
        for (int k = 0; k < DIGITS; k++) begin
            r[4*k +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return {n, r};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_conv(input logic [BIN_W-1:0] v, input logic s, input bit push);
        bin   = v;
        sgn   = s;
        start = 1'b1;
        if (push) sb.push_back(model(v, s));
        step();
        start = 1'b0;
    endtask

    // cyc0 = cycles already elapsed since the start cycle when called.
    task automatic wait_done(input string tag, input int cyc0);
        int   cyc;
        bit   seen;
        logic [4*DIGITS:0] exp;
        cyc  = cyc0;
        seen = 0;
        if (cyc == 1) check({tag, "_busy_rise"}, 64'(busy), 64'd1);
        while (!seen && cyc < LATENCY + 20) begin
            if (done === 1'b1) begin
                seen = 1;
            end else begin
                if (cyc == 10) begin
                    check({tag, "_hold_bcd"}, 64'(bcd), 64'(last_bcd));
                    check({tag, "_hold_neg"}, 64'(neg), 64'(last_neg));
                end
                step();
                cyc++;
            end
        end
        check({tag, "_done_seen"}, 64'(seen), 64'd1);
        if (seen) begin
            check({tag, "_latency"}, 64'(cyc), 64'(LATENCY));
            check({tag, "_busy_in_done"}, 64'(busy), 64'd1);
            check({tag, "_sb_nonempty"}, 64'(sb.size() > 0), 64'd1);
            if (sb.size() > 0) begin
                exp = sb.pop_front();
                check({tag, "_bcd"}, 64'(bcd), 64'(exp[4*DIGITS-1:0]));
                check({tag, "_neg"}, 64'(neg), 64'(exp[4*DIGITS]));
                last_bcd = exp[4*DIGITS-1:0];
                last_neg = exp[4*DIGITS];
            end
            step();
            check({tag, "_done_fall"}, 64'(done), 64'd0);
            check({tag, "_busy_fall"}, 64'(busy), 64'd0);
        end
    endtask

    task automatic expect_quiet(input string tag, input int n);
        int dones;
        dones = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (done === 1'b1) dones++;
        end
        check({tag, "_no_done"}, 64'(dones), 64'd0);
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        bin      = '0;
        sgn      = 1'b0;
        last_bcd = '0;
        last_neg = 1'b0;
        repeat (3) step();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_bcd",  64'(bcd),  64'd0);
        check("rst_neg",  64'(neg),  64'd0);
        rst_n = 1'b1;
        step();

        start_conv(32'd0, 1'b0, 1);
        wait_done("zero", 1);

        start_conv(32'd1234567890, 1'b0, 1);
        wait_done("dec10", 1);

        start_conv(32'hFFFF_FFFF, 1'b0, 1);
        wait_done("umax", 1);

        start_conv(32'hFFFF_FFFF, 1'b1, 1);
        wait_done("sneg1", 1);

        start_conv(32'h8000_0000, 1'b1, 1);
        wait_done("smin", 1);

        start_conv(32'h7FFF_FFFF, 1'b1, 1);
        wait_done("smax", 1);

        start_conv(32'd42, 1'b0, 1);
        repeat (3) step();
        start_conv(32'd99, 1'b0, 0);
        wait_done("busy_ign", 5);
        expect_quiet("busy_ign", 45);
        start_conv(32'd99, 1'b0, 1);
        wait_done("after_ign", 1);

        start_conv(32'd1234567890, 1'b0, 0);
        repeat (9) step();
        rst_n = 1'b0;
        step();
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_bcd",  64'(bcd),  64'd0);
        check("abort_neg",  64'(neg),  64'd0);
        check("abort_done", 64'(done), 64'd0);
        rst_n    = 1'b1;
        last_bcd = '0;
        last_neg = 1'b0;
        expect_quiet("abort", 45);
        start_conv(32'd7, 1'b0, 1);
        wait_done("post_abort", 1);

        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
